piso_serial_tx: RTL and testbench



---
 rtl/piso_serial_tx_pkg.sv | 22 ++
 rtl/piso_serial_tx_bit_tick_gen.sv | 44 ++++
 rtl/piso_serial_tx.sv | 153 +++++++++++++++
 tb/tb_piso_serial_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/piso_serial_tx_pkg.sv
// -----------------------------------------------------------------------------
// piso_serial_tx_pkg
// Shared definitions for the single-wire bit-serial link. The transmitter
// (piso_serial_tx) and the matching shift-in receiver both import this package
// so that state encodings and bit-order selectors agree on both ends.
//
// Contents:
//   tx_state_e  - link FSM state encoding (ST_IDLE = 0, ST_SHIFT = 1)
//   LSB_FIRST   - bit-order selector value: least significant bit sent first
//   MSB_FIRST   - bit-order selector value: most significant bit sent first
// -----------------------------------------------------------------------------
package piso_serial_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_e;

    localparam bit LSB_FIRST = 1'b0;
    localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_serial_tx_bit_tick_gen.sv
// -----------------------------------------------------------------------------
// bit_tick_gen
// Bit-period timer for the serial link. While enabled it counts clock cycles
// 0..CLK_DIV-1 and wraps; tick marks the last cycle of every bit-period so the
// owner knows when to advance to the next bit. When disabled the counter is
// parked at zero so the next enable starts a fresh, full-length bit-period.
//
// Parameters:
//   CLK_DIV - clock cycles per bit (>= 1)
// Ports:
//   clk    in  - rising-edge clock
//   rst_n  in  - asynchronous active-low reset
//   enable in  - count while high, hold at zero while low
//   tick   out - high on the last cycle of each bit-period (only while enabled)
// -----------------------------------------------------------------------------
module bit_tick_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // Divider counter. With CLK_DIV = 1 the terminal value is zero, so the
    // counter never leaves zero and every enabled cycle is a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!enable || (div_cnt == CNT_LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = enable && (div_cnt == CNT_LAST);

endmodule

// File: rtl/piso_serial_tx.sv
// -----------------------------------------------------------------------------
// piso_serial_tx
// Parallel-in / serial-out transmitter for the single-wire bit-serial link.
// A WIDTH-bit word is taken on a valid/ready handshake and shifted out one bit
// per CLK_DIV-cycle bit-period, with frame marking the data bits. All outputs
// are registered; sout_b is the continuous complement of the sout register.
//
// Parameters:
//   WIDTH     - word width (>= 2)
//   CLK_DIV   - clock cycles per bit (>= 1)
//   MSB_FIRST - 0: LSB first, 1: MSB first
// Ports:
//   clk        in  - rising-edge clock
//   rst_n      in  - asynchronous active-low reset
//   load_valid in  - producer offers load_data
//   load_ready out - transmitter can accept a word this cycle
//   load_data  in  - word to send, sampled only on acceptance
//   sout       out - serial data
//   sout_b     out - always ~sout
//   frame      out - high while a data bit is on sout
//   busy       out - high from the cycle after acceptance to the end of the frame
//   done       out - one-cycle pulse after the last bit-period
// -----------------------------------------------------------------------------
module piso_serial_tx #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sout,
    output logic             sout_b,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    import piso_serial_tx_pkg::*;

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam bit SEND_MSB = (MSB_FIRST == int'(piso_serial_tx_pkg::MSB_FIRST));

    tx_state_e        state;
    tx_state_e        next_state;
    logic [WIDTH-1:0] shift_reg;
    logic [IDX_W-1:0] bit_idx;
    logic             tick;
    logic             accept;
    logic             last_bit;
    logic             load_head;
    logic             shift_next;
    logic             sout_d;
    logic             frame_d;
    logic             busy_d;
    logic             ready_d;
    logic             done_d;

    bit_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state == ST_SHIFT),
        .tick   (tick)
    );

    // load_ready is a register that is high exactly in IDLE, so it doubles as
    // the acceptance qualifier and keeps load_valid during SHIFT harmless.
    assign accept   = load_valid && load_ready;
    assign last_bit = tick && (bit_idx == IDX_LAST);

    // The shift register always holds the bit currently on sout at its "head"
    // end, so the next bit to send sits one position behind it.
    assign load_head  = SEND_MSB ? load_data[WIDTH-1] : load_data[0];
    assign shift_next = SEND_MSB ? shift_reg[WIDTH-2] : shift_reg[1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: leave IDLE on a handshake, leave SHIFT when the last
    // bit-period of the word ends.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept)   next_state = ST_SHIFT;
            ST_SHIFT: if (last_bit) next_state = ST_IDLE;
        endcase
    end

    // Output decode. Outputs are registered, so this computes the value each
    // output will take in the next cycle from the upcoming state. done is
    // derived from the SHIFT->IDLE transition, so it can never overlap frame.
    always_comb begin
        ready_d = (next_state == ST_IDLE);
        frame_d = (next_state == ST_SHIFT);
        busy_d  = (next_state == ST_SHIFT);
        done_d  = (state == ST_SHIFT) && last_bit;
        sout_d  = 1'b0;
        if (state == ST_IDLE) begin
            if (accept) sout_d = load_head;
        end else if (!tick) begin
            sout_d = sout;
        end else if (!last_bit) begin
            sout_d = shift_next;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_ready <= 1'b1;
            sout       <= 1'b0;
            frame      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            load_ready <= ready_d;
            sout       <= sout_d;
            frame      <= frame_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Datapath: capture the word on acceptance, then advance one bit per
    // bit-period. bit_idx returns to zero after the final bit so it never
    // counts past WIDTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_idx   <= '0;
        end else if (accept) begin
            shift_reg <= load_data;
            bit_idx   <= '0;
        end else if ((state == ST_SHIFT) && tick) begin
            shift_reg <= SEND_MSB ? (shift_reg << 1) : (shift_reg >> 1);
            bit_idx   <= last_bit ? '0 : bit_idx + 1'b1;
        end
    end

    assign sout_b = ~sout;

endmodule

// File: tb/tb_piso_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_serial_tx
// Directed bench for piso_serial_tx. Two instances run side by side:
//   dut_a : WIDTH=8, CLK_DIV=1, LSB first
//   dut_b : WIDTH=8, CLK_DIV=3, MSB first
// Inputs are driven and outputs sampled on the falling clock edge. Each
// observation packs {sout, sout_b, frame, busy, load_ready, done}.
// -----------------------------------------------------------------------------
module tb_piso_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic       a_ready, a_sout, a_sout_b, a_frame, a_busy, a_done;
    logic       b_ready, b_sout, b_sout_b, b_frame, b_busy, b_done;
    logic [5:0] a_vec, b_vec;

    int tests_run    = 0;
    int tests_failed = 0;

    bit exp_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    bit exp_c3 [8] = '{1, 1, 0, 0, 0, 0, 1, 1};
    bit exp_5a [8] = '{0, 1, 0, 1, 1, 0, 1, 0};
    bit exp_01 [8] = '{1, 0, 0, 0, 0, 0, 0, 0};

    piso_serial_tx #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(0)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (a_valid),
        .load_ready (a_ready),
        .load_data  (a_data),
        .sout       (a_sout),
        .sout_b     (a_sout_b),
        .frame      (a_frame),
        .busy       (a_busy),
        .done       (a_done)
    );

    piso_serial_tx #(.WIDTH(8), .CLK_DIV(3), .MSB_FIRST(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (b_valid),
        .load_ready (b_ready),
        .load_data  (b_data),
        .sout       (b_sout),
        .sout_b     (b_sout_b),
        .frame      (b_frame),
        .busy       (b_busy),
        .done       (b_done)
    );

    assign a_vec = {a_sout, a_sout_b, a_frame, a_busy, a_ready, a_done};
    assign b_vec = {b_sout, b_sout_b, b_frame, b_busy, b_ready, b_done};

    always #5 clk = ~clk;

    // Expected packed output vector; busy tracks frame and sout_b is ~sout.
    function automatic logic [5:0] expv(input bit s, input bit f, input bit r, input bit d);
        return {s, ~s, f, f, r, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed[5:0], expected[5:0]);
        end
    endtask

    task automatic applyStimulus(input bit to_b, input logic valid, input logic [7:0] data);
        if (to_b) begin
            b_valid = valid;
            b_data  = data;
        end else begin
            a_valid = valid;
            a_data  = data;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 1'($urandom), 8'($urandom));
        applyStimulus(1, 1'($urandom), 8'($urandom));
        #13;
        checkOutput("reset A", a_vec, expv(0, 0, 1, 0));
        checkOutput("reset B", b_vec, expv(0, 0, 1, 0));
        @(negedge clk);
        applyStimulus(0, 0, 8'h00);
        applyStimulus(1, 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] A5 on CLK_DIV=1 LSB-first, with a load_valid pulse of 33 mid-frame");
        applyStimulus(0, 1, 8'hA5);
        checkOutput("t1 ready c0", a_vec, expv(0, 0, 1, 0));
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t1 bit%0d", i), a_vec, expv(exp_a5[i], 1, 0, 0));
            if (i == 2) applyStimulus(0, 1, 8'h33);
            else        applyStimulus(0, 0, 8'h33);
            @(negedge clk);
        end
        checkOutput("t1 done c9", a_vec, expv(0, 0, 1, 1));
        @(negedge clk);
        checkOutput("t1 idle c10", a_vec, expv(0, 0, 1, 0));

        $display("[TB] C3 on CLK_DIV=3 MSB-first");
        applyStimulus(1, 1, 8'hC3);
        checkOutput("t2 ready c0", b_vec, expv(0, 0, 1, 0));
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            checkOutput($sformatf("t2 cyc%0d", i + 1), b_vec, expv(exp_c3[i / 3], 1, 0, 0));
            applyStimulus(1, 0, 8'h00);
            @(negedge clk);
        end
        checkOutput("t2 done c25", b_vec, expv(0, 0, 1, 1));
        @(negedge clk);
        checkOutput("t2 idle c26", b_vec, expv(0, 0, 1, 0));

        $display("[TB] back-to-back FF then 00");
        applyStimulus(0, 1, 8'hFF);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t3 ff bit%0d", i), a_vec, expv(1, 1, 0, 0));
            if (i == 3) applyStimulus(0, 1, 8'h00);
            @(negedge clk);
        end
        checkOutput("t3 done1", a_vec, expv(0, 0, 1, 1));
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t3 00 bit%0d", i), a_vec, expv(0, 1, 0, 0));
            applyStimulus(0, 0, 8'h00);
            @(negedge clk);
        end
        checkOutput("t3 done2", a_vec, expv(0, 0, 1, 1));
        @(negedge clk);
        checkOutput("t3 idle", a_vec, expv(0, 0, 1, 0));

        $display("[TB] reset in the middle of 5A, then 01");
        applyStimulus(0, 1, 8'h5A);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t4 5a bit%0d", i), a_vec, expv(exp_5a[i], 1, 0, 0));
            applyStimulus(0, 0, 8'h00);
            if (i < 4) @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t4 async clear", a_vec, expv(0, 0, 1, 0));
        @(negedge clk);
        checkOutput("t4 held reset", a_vec, expv(0, 0, 1, 0));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t4 no done", a_vec, expv(0, 0, 1, 0));
        applyStimulus(0, 1, 8'h01);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t4 01 bit%0d", i), a_vec, expv(exp_01[i], 1, 0, 0));
            applyStimulus(0, 0, 8'h00);
            @(negedge clk);
        end
        checkOutput("t4 done", a_vec, expv(0, 0, 1, 1));
        checkOutput("t4 B untouched", b_vec, expv(0, 0, 1, 0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
